dbus_if: RTL
============

# dbus_if

Data-bus interface between the memory-access stage and the system data bus. It converts the single-cycle combinational access request from the memory-access stage (chip-enable, write-enable, byte-select, address, write data) into a request/grant/response handshake on an external bus. It raises a pipeline stall until the access completes and returns read data to the memory-access stage for sub-word extraction. It sits between the memory-access stage and the bus fabric; its stall request goes to the pipeline controller.

## Interface
- DBUS_TIMEOUT, default 64: cycles allowed in REQ+WAIT before abort (used only with DBUS_TIMEOUT_EN).
- clk  in  1  rising-edge clock.
- rst  in  1  reset rst, synchronous, active-high.
- mem_ce_i  in  1  access request from memory-access stage.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_addr_i  in  32  byte address (passed unaligned bits untouched).
- mem_sel_i  in  4  byte lanes.
- mem_data_i  in  32  store data (already lane-replicated).
- mem_rdata_o  out  32  load data back to memory-access stage.
- stall_i  in  1  pipeline held this cycle; completed result must be kept.
- flush_i  in  1  kill current memory-stage instruction.
- stall_req_o  out  1  request pipeline stall.
- bus_req_o, bus_we_o  out  1  bus request / write.
- bus_addr_o  out  32; bus_sel_o  out  4; bus_wdata_o  out  32.
- bus_gnt_i  in  1  request accepted this cycle.
- bus_rvalid_i  in  1  read data valid; bus_rdata_i  in  32.
- bus_err_o  out  1  one-cycle timeout pulse.

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE: on mem_ce_i=1 and flush_i=0, latch we/addr/sel/wdata into request registers, go REQ.
- REQ: bus_req_o=1 with latched fields held stable; on bus_gnt_i: store -> DONE (posted write), load -> WAIT. flush_i before grant -> IDLE, request withdrawn.
- WAIT: on bus_rvalid_i capture bus_rdata_i -> DONE. flush_i -> DRAIN. bus_rvalid_i is only honoured in WAIT/DRAIN.
- DRAIN: await bus_rvalid_i, discard data -> IDLE. No new request issued.
- DONE: mem_rdata_o = captured data (0 for stores). stall_i=1 -> remain DONE; else -> IDLE. flush_i in DONE -> IDLE.
- stall_req_o = mem_ce_i & ~flush_i & (state != DONE) — combinational, asserted in the IDLE cycle that first sees the request.
- mem_rdata_o = 0 in every state except DONE.
- Granted stores are committed; flush does not cancel them.
- Reset mid-transaction: all state cleared, bus_req_o drops; outstanding bus response ignored.

## Timing
- Reset values: state IDLE, bus_req_o/bus_we_o/bus_err_o 0, bus_addr_o/bus_sel_o/bus_wdata_o 0, mem_rdata_o 0, stall_req_o follows its equation (0 while mem_ce_i=0).
- Bus fields are registered; bus_req_o rises the cycle after the IDLE cycle that sees mem_ce_i.
- Minimum load: C0 IDLE (stall), C1 REQ+gnt, C2 WAIT+rvalid, C3 DONE (stall_req_o=0, data valid) -> 3 stall cycles.
- Minimum store: C0 IDLE, C1 REQ+gnt, C2 DONE -> 2 stall cycles.
- Back-to-back: DONE->IDLE, then a new request is latched on the following IDLE cycle.

## Configuration
- DBUS_TIMEOUT_EN defined: counter cleared on REQ entry, counts in REQ and WAIT; on reaching DBUS_TIMEOUT, drop bus_req_o, go DONE with mem_rdata_o=0, bus_err_o=1 for one cycle. Late rvalid afterwards ignored.
- Undefined: no counter, bus_err_o tied 0, waits indefinitely.

## Structure
- Shared defines: state encodings, `RegBus` width, `ZeroWord`, `ChipEnable`/`WriteEnable` levels.
- One sub-module natural: dbus_wdog (timeout counter, start/clear/expire), instantiated only under DBUS_TIMEOUT_EN.

## Test plan
- Load addr 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF -> stall_req_o high 3 cycles, mem_rdata_o=0xDEADBEEF in DONE.
- Store sel 4'b0100 data 0x5A5A5A5A, gnt delayed 4 cycles -> bus fields stable while bus_req_o=1, DONE 1 cycle after gnt.
- Load completes with stall_i held 3 cycles -> remains DONE, mem_rdata_o held, no new bus_req_o.
- Flush in REQ before gnt -> bus_req_o drops next cycle; flush in WAIT -> DRAIN, rvalid 0x1234 discarded, mem_rdata_o stays 0.
- Reset asserted in WAIT -> next cycle IDLE, all outputs 0, subsequent rvalid ignored.
- DBUS_TIMEOUT_EN, DBUS_TIMEOUT=8, no gnt -> after 8 cycles bus_err_o pulses once, mem_rdata_o=0, stall released.

Source files
------------

// File: rtl/dbus_if_pkg.sv
// Shared definitions for the data-bus interface: state encodings, bus width, enable levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dbus_if_pkg;

    localparam int REG_BUS = 32;

    typedef logic [REG_BUS-1:0] reg_bus_t;

    localparam reg_bus_t ZERO_WORD    = '0;
    localparam logic     CHIP_ENABLE  = 1'b1;
    localparam logic     WRITE_ENABLE = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // Request fields captured from the memory-access stage and driven onto the bus.
    typedef struct packed {
        logic     we;
        reg_bus_t addr;
        logic [3:0] sel;
        reg_bus_t wdata;
    } req_t;

endpackage

// File: rtl/dbus_if_wdog.sv
// Bus-access watchdog: counts cycles spent in REQ/WAIT and flags expiry.
// Latency: expire is combinational in the TIMEOUT-th counted cycle after start.
// Backpressure: none; counter saturates at TIMEOUT-1 so expire holds until cleared.
module dbus_if_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic count_en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Clear on a new transaction, otherwise count busy cycles up to the limit.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt <= '0;
        end else if (count_en && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = count_en && (cnt == LAST);

endmodule

// File: rtl/dbus_if.sv
// Data-bus interface: turns a memory-stage access into a req/gnt/rvalid bus transaction.
// Latency: load >= 3 stall cycles (IDLE, REQ, WAIT), store >= 2 (IDLE, REQ); result shown in DONE.
// Backpressure: stall_req_o holds the pipeline until DONE; stall_i keeps DONE and its data.
// Optional timeout watchdog enabled by defining DBUS_TIMEOUT_EN (length DBUS_TIMEOUT).
module dbus_if
    import dbus_if_pkg::*;
#(
    parameter int DBUS_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_rdata_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    req_t       req_q;
    reg_bus_t   rdata_q;
    logic       err_q;
    logic       expire;
    logic       timeout_hit;
    logic       launch;

    assign launch = (state == ST_IDLE) && (state_nxt == ST_REQ);

`ifdef DBUS_TIMEOUT_EN
    dbus_if_wdog #(
        .TIMEOUT (DBUS_TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .start    (launch),
        .count_en ((state == ST_REQ) || (state == ST_WAIT)),
        .expire   (expire)
    );
`else
    // Without the watchdog the timeout length has no effect; accesses wait indefinitely.
    logic unused_timeout;
    assign unused_timeout = (DBUS_TIMEOUT != 0);
    assign expire         = 1'b0;
`endif

    // Next-state selection; grant/response win over a simultaneous timeout.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((mem_ce_i == CHIP_ENABLE) && !flush_i) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_gnt_i) begin
                    // A granted store is posted and committed even if flushed;
                    // a granted load that is flushed still owes a response.
                    if (req_q.we) begin
                        state_nxt = flush_i ? ST_IDLE : ST_DONE;
                    end else begin
                        state_nxt = flush_i ? ST_DRAIN : ST_WAIT;
                    end
                end else if (flush_i) begin
                    state_nxt = ST_IDLE;
                end else if (expire) begin
                    state_nxt   = ST_DONE;
                    timeout_hit = 1'b1;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    state_nxt = bus_rvalid_i ? ST_IDLE : ST_DRAIN;
                end else if (bus_rvalid_i) begin
                    state_nxt = ST_DONE;
                end else if (expire) begin
                    state_nxt   = ST_DONE;
                    timeout_hit = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bus_rvalid_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (flush_i || !stall_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, request latch, read-data capture and one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            rdata_q <= ZERO_WORD;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= timeout_hit;
            if (launch) begin
                req_q.we    <= (mem_we_i == WRITE_ENABLE);
                req_q.addr  <= mem_addr_i;
                req_q.sel   <= mem_sel_i;
                req_q.wdata <= mem_data_i;
                // Stores and timed-out loads report zero data.
                rdata_q     <= ZERO_WORD;
            end
            if ((state == ST_WAIT) && bus_rvalid_i && !flush_i) begin
                rdata_q <= bus_rdata_i;
            end
        end
    end

    assign bus_req_o   = (state == ST_REQ);
    assign bus_we_o    = req_q.we;
    assign bus_addr_o  = req_q.addr;
    assign bus_sel_o   = req_q.sel;
    assign bus_wdata_o = req_q.wdata;
    assign bus_err_o   = err_q;

    assign mem_rdata_o = (state == ST_DONE) ? rdata_q : ZERO_WORD;
    assign stall_req_o = (mem_ce_i == CHIP_ENABLE) && !flush_i && (state != ST_DONE);

endmodule
